// File: rtl/imem_fetch_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_controller_if
// Brief    : Loader, fetch, decode and memory-port signals of the fetch controller
// Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_controller_if;
  logic        Start;
  logic        LoadReq;
  logic        LoadValid;
  logic [31:0] LoadAddr;
  logic [31:0] LoadData;
  logic        Halt;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        DecodeReady;
  logic [31:0] ImemAddress;
  logic        ImemWrEn;
  logic [31:0] ImemWrData;
  logic [31:0] ImemInstruction;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic [1:0]  State;
  logic        AddrError;
  logic [31:0] FetchCount;

  modport master (
    input  Start, LoadReq, LoadValid, LoadAddr, LoadData, Halt, Redirect,
           RedirectTarget, DecodeReady, ImemInstruction,
    output ImemAddress, ImemWrEn, ImemWrData, Instr, InstrPC, InstrValid,
           State, AddrError, FetchCount
  );

  modport slave (
    output Start, LoadReq, LoadValid, LoadAddr, LoadData, Halt, Redirect,
           RedirectTarget, DecodeReady, ImemInstruction,
    input  ImemAddress, ImemWrEn, ImemWrData, Instr, InstrPC, InstrValid,
           State, AddrError, FetchCount
  );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_controller
// Brief    : Shares the instruction-memory port between loader and fetch; PC,
//            redirect/halt handling and registered valid/ready delivery.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_controller #(
  parameter int          DEPTH    = 128,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                           clk,
  input  logic                           reset,
  imem_fetch_controller_if.master        bus
);

  localparam logic [1:0]  ST_BOOT   = 2'd0;
  localparam logic [1:0]  ST_LOAD   = 2'd1;
  localparam logic [1:0]  ST_RUN    = 2'd2;
  localparam logic [1:0]  ST_HALTED = 2'd3;
  localparam logic [31:0] C_DEPTH   = 32'(DEPTH);
  localparam logic [31:0] C_LAST    = 32'(DEPTH - 1);

  logic [1:0]  state_q,  state_d;
  logic [31:0] pc_q,     pc_d;
  logic [31:0] instr_q,  instr_d;
  logic [31:0] ipc_q,    ipc_d;
  logic        valid_q,  valid_d;
  logic        err_q,    err_d;
  logic [31:0] count_q,  count_d;

  logic w_load_in_range;
  logic w_accept;
  logic w_flush;

  assign w_load_in_range = bus.LoadAddr < C_DEPTH;
  assign w_accept        = valid_q && bus.DecodeReady;
  // A redirect only takes effect in RUN when no halt outranks it.
  assign w_flush         = (state_q == ST_RUN) && !bus.Halt && bus.Redirect;

  assign bus.ImemAddress = (state_q == ST_LOAD) ? bus.LoadAddr : pc_q;
  assign bus.ImemWrEn    = (state_q == ST_LOAD) && bus.LoadValid && w_load_in_range;
  assign bus.ImemWrData  = bus.LoadData;
  assign bus.Instr       = instr_q;
  assign bus.InstrPC     = ipc_q;
  assign bus.InstrValid  = valid_q;
  assign bus.State       = state_q;
  assign bus.AddrError   = err_q;
  assign bus.FetchCount  = count_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    err_d   = err_q;
    count_d = count_q;

    if (w_accept && !w_flush) count_d = count_q + 32'd1;
    if (w_accept)             valid_d = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (bus.LoadReq) begin
          state_d = ST_LOAD;
        end else if (bus.Start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
          valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.LoadValid && !w_load_in_range) err_d = 1'b1;
        if (!bus.LoadReq) state_d = ST_BOOT;
      end
      ST_RUN: begin
        if (bus.Halt) begin
          state_d = ST_HALTED;
        end else if (bus.Redirect) begin
          valid_d = 1'b0;
          if (bus.RedirectTarget < C_DEPTH) begin
            pc_d = bus.RedirectTarget;
          end else begin
            err_d   = 1'b1;
            state_d = ST_HALTED;
          end
        end else if (!valid_q || bus.DecodeReady) begin
          instr_d = bus.ImemInstruction;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          if (pc_q == C_LAST) state_d = ST_HALTED;
          else                pc_d    = pc_q + 32'd1;
        end
      end
      default: begin
        if (bus.LoadReq) begin
          state_d = ST_LOAD;
        end else if (bus.Start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_controller
// Brief    : Directed and randomized bench for imem_fetch_controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_controller;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_fetch_controller_if bus();

  imem_fetch_controller #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment memory, written only through the DUT's port.
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk)
    if (bus.ImemWrEn && bus.ImemAddress < 32'(DEPTH)) mem[bus.ImemAddress[6:0]] <= bus.ImemWrData;
  assign bus.ImemInstruction = (bus.ImemAddress < 32'(DEPTH)) ? mem[bus.ImemAddress[6:0]] : 32'hDEADBEEF;

  // Reference model: 0=BOOT 1=LOAD 2=RUN 3=HALTED
  int          m_state;
  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
  bit          m_valid, m_err;
  logic [31:0] m_mem [DEPTH];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit we);
    bit acc;
    if (we) m_mem[bus.LoadAddr[6:0]] = bus.LoadData;
    if (reset) begin
      m_reset();
      return;
    end
    acc = m_valid && bus.DecodeReady;
    if (m_state == 2) begin
      if (bus.Halt) begin
        m_state = 3;
        if (acc) begin m_valid = 0; m_cnt++; end
      end else if (bus.Redirect) begin
        m_valid = 0;
        if (bus.RedirectTarget < DEPTH) m_pc = bus.RedirectTarget;
        else begin m_err = 1; m_state = 3; end
      end else if (!m_valid || bus.DecodeReady) begin
        if (acc) m_cnt++;
        m_instr = m_mem[m_pc[6:0]];
        m_ipc   = m_pc;
        m_valid = 1;
        if (m_pc == DEPTH - 1) m_state = 3;
        else m_pc++;
      end
    end else begin
      if (acc) begin m_valid = 0; m_cnt++; end
      if (m_state == 1) begin
        if (bus.LoadValid && bus.LoadAddr >= DEPTH) m_err = 1;
        if (!bus.LoadReq) m_state = 0;
      end else if (bus.LoadReq) begin
        m_state = 1;
      end else if (bus.Start) begin
        m_state = 2; m_pc = 0; m_valid = 0;
        if (m_state == 3 || 1) begin end
      end
    end
  endtask

  // Called just after a negedge with inputs applied; ends at the next negedge.
  task automatic tick();
    bit          e_we;
    logic [31:0] e_addr;
    int          prev_state;
    #1;
    e_we   = (m_state == 1) && bus.LoadValid && (bus.LoadAddr < DEPTH);
    e_addr = (m_state == 1) ? bus.LoadAddr : m_pc;
    chk("ImemAddress", bus.ImemAddress, e_addr);
    chk("ImemWrEn", 32'(bus.ImemWrEn), 32'(e_we));
    chk("ImemWrData", bus.ImemWrData, bus.LoadData);
    chk("State", 32'(bus.State), 32'(m_state));
    chk("Instr", bus.Instr, m_instr);
    chk("InstrPC", bus.InstrPC, m_ipc);
    chk("InstrValid", 32'(bus.InstrValid), 32'(m_valid));
    chk("AddrError", 32'(bus.AddrError), 32'(m_err));
    chk("FetchCount", bus.FetchCount, m_cnt);
    prev_state = m_state;
    model_step(e_we);
    // Restart from HALTED also clears the sticky error.
    if (!reset && prev_state == 3 && !bus.LoadReq && bus.Start) m_err = 0;
    @(negedge clk);
  endtask

  task automatic wait_ipc(input logic [31:0] t);
    int b = 0;
    while (!(bus.InstrValid && bus.InstrPC == t) && b < 200) begin
      tick();
      b++;
    end
    chk("wait_ipc", bus.InstrPC, t);
  endtask

  initial begin
    reset = 1'b1;
    bus.Start = 0; bus.LoadReq = 0; bus.LoadValid = 0; bus.LoadAddr = 0; bus.LoadData = 0;
    bus.Halt = 0; bus.Redirect = 0; bus.RedirectTarget = 0; bus.DecodeReady = 0;
    @(negedge clk);
    @(negedge clk);
    m_reset();
    reset = 1'b0;

    // Fill the whole memory through the loader.
    bus.LoadReq = 1; tick();
    for (int i = 0; i < DEPTH; i++) begin
      bus.LoadValid = 1; bus.LoadAddr = 32'(i); bus.LoadData = $urandom; tick();
    end
    bus.LoadAddr = 0; bus.LoadData = 32'h00221820; tick();
    bus.LoadAddr = 1; bus.LoadData = 32'h0125502A; tick();
    bus.LoadValid = 0; bus.LoadReq = 0; tick();

    // Load-then-run
    bus.Start = 1; tick(); bus.Start = 0;
    bus.DecodeReady = 1; tick();
    chk("tp_instr0", bus.Instr, 32'h00221820);
    chk("tp_ipc0", bus.InstrPC, 32'd0);
    tick();
    chk("tp_instr1", bus.Instr, 32'h0125502A);
    chk("tp_ipc1", bus.InstrPC, 32'd1);
    chk("tp_cnt1", bus.FetchCount, 32'd1);

    // Stall at InstrPC=5
    wait_ipc(5);
    bus.DecodeReady = 0;
    repeat (3) tick();
    chk("stall_ipc", bus.InstrPC, 32'd5);
    chk("stall_addr", bus.ImemAddress, 32'd6);
    bus.DecodeReady = 1; tick();
    chk("stall_adv", bus.InstrPC, 32'd6);

    // Redirect flush
    wait_ipc(7);
    bus.Redirect = 1; bus.RedirectTarget = 40; tick(); bus.Redirect = 0;
    chk("flush_valid", 32'(bus.InstrValid), 32'd0);
    tick();
    chk("redir_ipc", bus.InstrPC, 32'd40);

    // Bad redirect target
    bus.Redirect = 1; bus.RedirectTarget = 200; tick(); bus.Redirect = 0;
    chk("bad_tgt_err", 32'(bus.AddrError), 32'd1);
    chk("bad_tgt_state", 32'(bus.State), 32'd3);
    bus.Start = 1; tick(); bus.Start = 0;
    chk("restart_clr", 32'(bus.AddrError), 32'd0);
    bus.Halt = 1; tick(); bus.Halt = 0;

    // Bad loader write
    bus.LoadReq = 1; tick();
    bus.LoadValid = 1; bus.LoadAddr = 128; bus.LoadData = 32'h12345678;
    #1 chk("bad_wr_en", 32'(bus.ImemWrEn), 32'd0);
    tick();
    bus.LoadValid = 0;
    chk("bad_wr_err", 32'(bus.AddrError), 32'd1);
    bus.LoadReq = 0; tick();

    // End of memory
    bus.Start = 1; tick(); bus.Start = 0;
    bus.Redirect = 1; bus.RedirectTarget = 126; tick(); bus.Redirect = 0;
    tick();
    chk("eom_ipc126", bus.InstrPC, 32'd126);
    tick();
    chk("eom_ipc127", bus.InstrPC, 32'd127);
    chk("eom_halted", 32'(bus.State), 32'd3);
    tick();
    chk("eom_valid_drop", 32'(bus.InstrValid), 32'd0);

    // Halt and Redirect together
    bus.Start = 1; tick(); bus.Start = 0;
    tick(); tick();
    bus.Halt = 1; bus.Redirect = 1; bus.RedirectTarget = 50; tick();
    bus.Halt = 0; bus.Redirect = 0;
    chk("hr_state", 32'(bus.State), 32'd3);
    chk("hr_pc", bus.ImemAddress, 32'd2);

    // Reset during LOAD
    bus.LoadReq = 1; tick();
    bus.LoadValid = 1; bus.LoadAddr = 3; bus.LoadData = 32'hCAFE0003; reset = 1; tick();
    reset = 0; bus.LoadReq = 0; bus.LoadValid = 0;
    chk("rst_state", 32'(bus.State), 32'd0);
    chk("rst_valid", 32'(bus.InstrValid), 32'd0);
    chk("rst_cnt", bus.FetchCount, 32'd0);
    chk("rst_instr", bus.Instr, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset              = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) bus.LoadReq = ~bus.LoadReq;
      bus.Start          = ($urandom_range(0, 24) == 0);
      bus.LoadValid      = $urandom_range(0, 1) == 1;
      bus.LoadAddr       = 32'($urandom_range(0, 135));
      bus.LoadData       = $urandom;
      bus.Halt           = ($urandom_range(0, 32) == 0);
      bus.Redirect       = ($urandom_range(0, 9) == 0);
      bus.RedirectTarget = 32'($urandom_range(0, 140));
      bus.DecodeReady    = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/imem_fetch_controller.md
Name: imem_fetch_controller

Overview:
Sequences the 128-word instruction memory (combinational read, word-addressed). It owns the memory's single address port and shares it between a program loader (writes, boot/halted time) and the fetch stage (reads, run time). It maintains the PC, handles branch/jump redirects and halt, and delivers instructions to decode through a registered valid/ready handshake.

Parameters:
DEPTH, 128, instruction memory words; legal word addresses are 0..DEPTH-1
RESET_PC, 0, word address fetched first after Start

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
Start  input  1  pulse; BOOT->RUN, or HALTED->RUN restart
LoadReq  input  1  level; request loader ownership of memory
LoadValid  input  1  loader write strobe
LoadAddr  input  32  loader word address
LoadData  input  32  loader write data
Halt  input  1  pulse; stop fetching
Redirect  input  1  branch/jump taken
RedirectTarget  input  32  new PC, word address
DecodeReady  input  1  decode accepts Instr this cycle
ImemAddress  output  32  memory address, combinational from state
ImemWrEn  output  1  memory write enable, combinational
ImemWrData  output  32  memory write data, equals LoadData
ImemInstruction  input  32  memory read data, same cycle
Instr  output  32  registered instruction to decode
InstrPC  output  32  word address of Instr
InstrValid  output  1  Instr valid
State  output  2  BOOT=0, LOAD=1, RUN=2, HALTED=3
AddrError  output  1  sticky, illegal address seen
FetchCount  output  32  count of accepted handshakes

Behaviour:
- Reset: State=BOOT, PC=RESET_PC, Instr=0, InstrPC=0, InstrValid=0, AddrError=0, FetchCount=0. ImemWrEn=0, ImemAddress=PC.
- BOOT: LoadReq=1 -> LOAD (priority over Start); else Start=1 -> RUN with PC=RESET_PC.
- LOAD: ImemAddress=LoadAddr. ImemWrEn=LoadValid && LoadAddr<DEPTH. A write with LoadAddr>=DEPTH is suppressed and sets AddrError. LoadReq=0 -> BOOT. No fetches; InstrValid stays 0.
- RUN: ImemAddress=PC, ImemWrEn=0. Priority order each cycle:
  1. Halt -> HALTED; no capture; PC holds. A pending Instr stays valid until accepted.
  2. Redirect -> InstrValid<=0 (flush; the current output is discarded even if DecodeReady=1; FetchCount is not incremented). If RedirectTarget<DEPTH then PC<=RedirectTarget; else AddrError<=1 and State<=HALTED.
  3. Advance condition (!InstrValid || DecodeReady) -> Instr<=ImemInstruction, InstrPC<=PC, InstrValid<=1. If PC==DEPTH-1, State<=HALTED with PC held; else PC<=PC+1.
  4. Otherwise (stall): Instr, InstrPC, InstrValid and PC hold.
- Fetch latency: the instruction at PC appears on Instr one cycle after it is addressed. Throughput is 1/cycle while DecodeReady=1.
- FetchCount increments on InstrValid && DecodeReady, except in a Redirect cycle. It wraps at 2^32.
- HALTED: no fetches. InstrValid clears once the pending Instr is accepted.
  - LoadReq=1 -> LOAD (priority over Start).
  - Start=1 -> RUN with PC=RESET_PC and InstrValid<=0; AddrError is cleared.
- LoadReq, LoadValid, Redirect and Halt are ignored in states where they are not listed. Start is ignored in RUN and LOAD.
- reset asserted in any state, including mid-load or mid-stall, returns to the reset values on the next edge. A write that is combinationally enabled in the reset cycle still occurs.

Test Plan:
- Load-then-run: reset; LoadReq=1; write 0x00221820 at address 0 and 0x0125502A at address 1; LoadReq=0; Start; DecodeReady=1 -> ImemWrEn pulses twice. Instr=0x00221820 with InstrPC=0, then InstrPC=1 on the next cycle. FetchCount increments 1/cycle.
- Stall: in RUN, drop DecodeReady for 3 cycles while Instr has InstrPC=5 -> Instr, InstrPC=5 and PC=6 hold. On DecodeReady=1, Instr advances to InstrPC=6 and FetchCount increments exactly once for InstrPC=5.
- Redirect flush: Redirect=1 with target 40 while InstrPC=7 and DecodeReady=1 -> next cycle InstrValid=0 and FetchCount is unchanged. The cycle after, InstrPC=40.
- Bad addresses: RedirectTarget=200 -> AddrError=1, State=HALTED. A loader write to address 128 -> ImemWrEn=0, AddrError=1.
- End of memory: run from PC=126 with DecodeReady=1 -> delivers InstrPC 126 and 127, then State=HALTED. InstrValid drops after 127 is accepted.
- Priority and reset: Halt and Redirect in the same cycle -> HALTED with PC unchanged. reset during LOAD -> State=BOOT, all outputs at reset values.
